// File: rtl/spi_mult4x4.sv
// Purpose : SPI-style slave that receives A then B (MSB first), multiplies them with a
//           sequential shift-add, then shifts the 2*WIDTH-bit product out on MISO.
// Latency : WIDTH+1 CLK compute; first product bit driven on the (TURNAROUND+1)-th SCLK
//           fall after the last received rise. Backpressure: none, the master owns SCLK.
//
// Ports:
//   CLK   system clock (at least 8x SCLK)
//   RST   synchronous active-high reset, highest priority
//   SCLK  serial clock from master, asynchronous
//   CS    chip select, active-high, asynchronous; deassertion aborts any transaction
//   MOSI  serial data in, sampled on qualified SCLK rises in RECV only
//   MISO  serial data out, registered, changes only on qualified SCLK falls
module spi_mult4x4 #(
    parameter int WIDTH       = 4,
    parameter int TURNAROUND  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic SCLK,
    input  logic CS,
    input  logic MOSI,
    output logic MISO
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW + 1);
    localparam int TW = $clog2(TURNAROUND + 1) + 1;

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] RECV_LAST = CW'(PW - 1);
    localparam logic [CW-1:0] COMP_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] SEND_LAST = CW'(PW);
    localparam logic [TW-1:0] TA_ONE    = TW'(1);
    localparam logic [TW-1:0] TA_DONE   = TW'(TURNAROUND);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_COMPUTE,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic edge_en;
    logic q_rise;
    logic q_fall;
    logic cs_start;

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    // An edge only counts once CS has been seen high for a full CLK, so an SCLK
    // rise arriving together with CS assertion is dropped.
    assign edge_en  = cs_s & cs_prev_q;
    assign q_rise   = edge_en & sclk_s & ~sclk_prev_q;
    assign q_fall   = edge_en & ~sclk_s & sclk_prev_q;
    assign cs_start = cs_s & ~cs_prev_q;

    // ------------------------------------------------------------------
    // Transaction FSM and datapath
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;  // RECV bits, COMPUTE steps, SEND bits
    logic [TW-1:0]   ta_cnt_q, ta_cnt_d;    // turnaround falls seen, saturating
    logic [PW-1:0]   shift_q, shift_d;      // {A, B}; B half shifts left while multiplying
    logic [PW-1:0]   prod_q, prod_d;        // accumulator, then output shift register
    logic            miso_q, miso_d;

    logic [PW-1:0]   partial;

    // MSB-first shift-add: the current multiplier bit is always shift_q[WIDTH-1].
    assign partial = shift_q[WIDTH-1] ? {{WIDTH{1'b0}}, shift_q[PW-1:WIDTH]} : '0;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        ta_cnt_d  = ta_cnt_q;
        shift_d   = shift_q;
        prod_d    = prod_q;
        miso_d    = 1'b0;

        if (state_q != S_IDLE && !cs_s) begin
            // CS dropped: abandon whatever was in flight.
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            ta_cnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cs_start) begin
                        state_d   = S_RECV;
                        bit_cnt_d = '0;
                        ta_cnt_d  = '0;
                        shift_d   = '0;
                    end
                end

                S_RECV: begin
                    if (q_rise) begin
                        shift_d = {shift_q[PW-2:0], mosi_s};
                        if (bit_cnt_q == RECV_LAST) begin
                            state_d   = S_COMPUTE;
                            bit_cnt_d = '0;
                            prod_d    = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_ONE;
                        end
                    end
                end

                S_COMPUTE: begin
                    // The master keeps clocking during compute, so turnaround falls
                    // are already being counted here.
                    if (q_fall && ta_cnt_q != TA_DONE) begin
                        ta_cnt_d = ta_cnt_q + TA_ONE;
                    end
                    if (bit_cnt_q == COMP_LAST) begin
                        state_d   = S_WAIT;
                        bit_cnt_d = '0;
                    end else begin
                        prod_d    = {prod_q[PW-2:0], 1'b0} + partial;
                        shift_d   = {shift_q[PW-1:WIDTH], shift_q[WIDTH-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end

                S_WAIT: begin
                    if (ta_cnt_q == TA_DONE) begin
                        state_d = S_SEND;
                    end else if (q_fall) begin
                        ta_cnt_d = ta_cnt_q + TA_ONE;
                    end
                end

                S_SEND: begin
                    miso_d = miso_q;
                    if (q_fall) begin
                        if (bit_cnt_q == SEND_LAST) begin
                            // Last bit has been held for a full SCLK period.
                            miso_d  = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            miso_d    = prod_q[PW-1];
                            prod_d    = {prod_q[PW-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + CNT_ONE;
                        end
                    end
                end

                S_DONE: begin
                    // Wait for CS to drop; handled by the abort path above.
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            ta_cnt_q  <= '0;
            shift_q   <= '0;
            prod_q    <= '0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ta_cnt_q  <= ta_cnt_d;
            shift_q   <= shift_d;
            prod_q    <= prod_d;
            miso_q    <= miso_d;
        end
    end

    assign MISO = miso_q;

endmodule

// File: tb/tb_spi_mult4x4.sv
// Bench for spi_mult4x4: table of operand pairs with hand-computed products,
// plus abort, reset-during-send and CS-low clocking sequences.
module tb_spi_mult4x4;

    logic CLK;
    logic RST;
    logic SCLK;
    logic CS;
    logic MOSI;
    logic MISO;

    int checks;
    int errors;

    spi_mult4x4 #(
        .WIDTH      (4),
        .TURNAROUND (4),
        .SYNC_STAGES(2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .SCLK(SCLK),
        .CS  (CS),
        .MOSI(MOSI),
        .MISO(MISO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
        end
    endtask

    // One SCLK period of 10 CLK: rise, MOSI update 2 CLK later, fall at +5.
    // pre is MISO at the rise, post is MISO 4 CLK after the rise.
    task automatic sclk_cycle(input logic nxt, output logic pre, output logic post);
        pre  = MISO;
        SCLK = 1'b1;
        repeat (2) @(negedge CLK);
        MOSI = nxt;
        repeat (2) @(negedge CLK);
        post = MISO;
        @(negedge CLK);
        SCLK = 1'b0;
        repeat (5) @(negedge CLK);
    endtask

    task automatic run_txn(input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] exp, input string tag);
        logic [7:0] din;
        logic [7:0] got;
        logic       pre, post, nxt;
        logic       zero_ok, stab_ok, done_ok;
        din     = {a, b};
        got     = '0;
        zero_ok = 1'b1;
        stab_ok = 1'b1;
        done_ok = 1'b1;
        CS   = 1'b1;
        MOSI = din[7];
        repeat (5) @(negedge CLK);
        for (int k = 1; k <= 20; k++) begin
            nxt = (k < 8) ? din[7-k] : 1'b0;
            sclk_cycle(nxt, pre, post);
            if (k <= 12) begin
                if (pre !== 1'b0 || post !== 1'b0) zero_ok = 1'b0;
            end else begin
                got = {got[6:0], pre};
                if (post !== pre) stab_ok = 1'b0;
            end
        end
        if (MISO !== 1'b0) done_ok = 1'b0;
        // DONE ignores further SCLK while CS stays high.
        for (int k = 0; k < 2; k++) begin
            sclk_cycle(1'b1, pre, post);
            if (pre !== 1'b0 || post !== 1'b0) done_ok = 1'b0;
        end
        check($sformatf("%s_zero_R1_R12", tag), {7'd0, zero_ok}, 8'd1);
        check($sformatf("%s_product", tag), got, exp);
        check($sformatf("%s_stable_at_rise", tag), {7'd0, stab_ok}, 8'd1);
        check($sformatf("%s_done_zero", tag), {7'd0, done_ok}, 8'd1);
        CS = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    initial begin
        logic pre, post;
        logic idle_ok;
        logic [7:0] din;

        checks = 0;
        errors = 0;

        vecs[0] = '{a: 4'b0001, b: 4'b0110, p: 8'h06};
        vecs[1] = '{a: 4'b1111, b: 4'b1111, p: 8'hE1};
        vecs[2] = '{a: 4'b0000, b: 4'b1010, p: 8'h00};
        vecs[3] = '{a: 4'b1001, b: 4'b0111, p: 8'h3F};
        vecs[4] = '{a: 4'b1101, b: 4'b1011, p: 8'h8F};

        RST  = 1'b1;
        SCLK = 1'b0;
        CS   = 1'b0;
        MOSI = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_miso", {7'd0, MISO}, 8'd0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        // Abort after 5 received bits, then a clean transaction.
        din  = 8'hFF;
        CS   = 1'b1;
        MOSI = din[7];
        repeat (5) @(negedge CLK);
        for (int k = 1; k <= 5; k++) sclk_cycle(1'b1, pre, post);
        CS = 1'b0;
        repeat (10) @(negedge CLK);
        check("abort_miso", {7'd0, MISO}, 8'd0);
        run_txn(4'b0011, 4'b0101, 8'h0F, "after_abort");

        // Reset pulse while bit5 (=1) of 0xE1 is on MISO.
        din  = 8'hFF;
        CS   = 1'b1;
        MOSI = din[7];
        repeat (5) @(negedge CLK);
        for (int k = 1; k <= 14; k++) sclk_cycle(1'b1, pre, post);
        check("pre_rst_miso", {7'd0, MISO}, 8'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("post_rst_miso", {7'd0, MISO}, 8'd0);
        CS = 1'b0;
        repeat (10) @(negedge CLK);
        run_txn(4'b0110, 4'b1001, 8'h36, "after_rst");

        // SCLK toggling with CS low must have no effect.
        idle_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sclk_cycle(k[0], pre, post);
            if (pre !== 1'b0 || post !== 1'b0) idle_ok = 1'b0;
        end
        check("cs_low_idle", {7'd0, idle_ok}, 8'd1);
        run_txn(4'b0010, 4'b0111, 8'h0E, "after_cs_low");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_mult4x4.md
Name: spi_mult4x4

Overview:
- SPI-style serial slave that receives two unsigned operands, A then B, each MSB first.
- Multiplies them and shifts the product back out on MISO, MSB first, after a fixed turnaround.
- All logic runs on the system clock CLK; SCLK, CS and MOSI are asynchronous inputs that are synchronized and edge-detected internally.
- Used as a small arithmetic peripheral behind a serial master.

Parameters:
- WIDTH, 4, operand width in bits. Product is 2*WIDTH bits.
- TURNAROUND, 4, number of idle SCLK cycles between the last received bit and the first driven product bit.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).

Ports:
- CLK  input  1  system clock; must run at least 8x the SCLK frequency.
- RST  input  1  reset.
- SCLK  input  1  serial clock from the master; asynchronous to CLK.
- CS  input  1  chip select, active-high; asynchronous.
- MOSI  input  1  serial data in; the master changes it just after SCLK rising edges.
- MISO  output  1  serial data out, registered.

Behaviour:
- Interface: one clock (CLK); reset (RST) is synchronous and active-high.
- Reset: FSM goes to IDLE; shift registers, bit counter and product are cleared; MISO=0.
- Synchronization: SCLK, CS and MOSI each pass through SYNC_STAGES flops. Edge detection compares the last two synchronized SCLK samples, giving a 1-CLK rise pulse and a 1-CLK fall pulse.
- Edge qualification: an SCLK edge counts only if synchronized CS was already 1 in the previous CLK cycle. An SCLK rise coincident with CS assertion is therefore ignored.
- IDLE: MISO=0. When synchronized CS rises, go to RECV with bit counter = 0.
- RECV: on each qualified SCLK rise, shift synchronized MOSI into a 2*WIDTH-bit input register, MSB first.
  - The first WIDTH bits are A (MSB first); the next WIDTH bits are B (MSB first).
  - After the 2*WIDTH-th bit, go to COMPUTE.
- COMPUTE: sequential unsigned shift-add multiply, one partial product per CLK, done in WIDTH+1 CLK cycles. No overflow is possible (2*WIDTH-bit result). Then go to WAIT.
- WAIT: MISO=0. Count TURNAROUND qualified SCLK falls, then go to SEND.
  - The turnaround count starts with the first fall after the last received rise.
- SEND: on each qualified SCLK fall, drive the next product bit on MISO, starting with bit 2*WIDTH-1.
  - MISO changes only on falls, so it is stable at every SCLK rise.
  - The last bit is held until the next qualified fall; then MISO=0 and the FSM goes to DONE.
- DONE: MISO=0. Ignore SCLK until CS deasserts, then go to IDLE.
- Worked timing (WIDTH=4, TURNAROUND=4), with SCLK rises R1.. counted after CS assertion:
  - Bits are captured at R1..R8.
  - MISO=0 through falls F8..F11.
  - Product bit7 is driven at F12, so it is valid at R13; bit0 is valid at R20.
- CS deassert in any state (mid-receive, compute, wait or send): abort on that CLK to IDLE, MISO=0, partial data discarded. A new transaction needs a fresh CS rise.
- RST has priority over all other events, including mid-transaction.
- SCLK edges while CS=0 are ignored.
- MOSI is ignored outside RECV.

Test Plan:
- A=0001, B=0110 sent MSB first over 8 SCLK rises (SCLK period = 10 CLK), then 12 more SCLK cycles -> MISO sampled at R13..R20 = 0,0,0,0,0,1,1,0 (product 0x06).
- A=1111, B=1111 -> MISO at R13..R20 = 1,1,1,0,0,0,0,1 (0xE1); A=0000, B=1010 -> all zeros.
- MISO held at 0 during RECV and at every rise R9..R12; MISO stable across each rise (no change within ±4 CLK of the rise).
- CS dropped after 5 received bits, then a full new transaction with A=0011, B=0101 -> the aborted data is ignored and MISO returns 0x0F at R13..R20.
- RST asserted for 1 CLK during SEND -> MISO=0 on the next CLK; FSM in IDLE; a following transaction completes correctly.
- SCLK toggling with CS=0 for 20 cycles -> MISO stays 0 and no state change occurs.
